prog_addr_decode: RTL and testbench

- Register-programmable chip-select decoder for the 6502 bus; successor to the fixed addr_decode.
- Provides NUM_CS address windows, each a base/mask pair matched by (addr & mask) == base, resolved by fixed priority into a one-hot chip-select vector.
- The window table is rewritten at run time through a small indexed config port with staged, atomic apply, lock, and sticky overlap/miss status.
- Sits between the CPU address bus and all peripheral/memory chip selects; the top level routes one of its own outputs to cfg_cs.

---
 rtl/prog_addr_decode_pkg.sv | 45 ++++
 rtl/prog_addr_decode_cs_window_match.sv | 14 +
 rtl/prog_addr_decode.sv | 182 ++++++++++++++++++
 tb/tb_prog_addr_decode.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_addr_decode_pkg.sv
// Shared constants for the programmable chip-select decoder: register map,
// field positions, channel names and the power-on window table.
package prog_addr_decode_pkg;

    localparam int REG_W  = 16;
    localparam int MAX_CS = 16;

    localparam logic [2:0] REG_SEL     = 3'd0;
    localparam logic [2:0] REG_BASE_LO = 3'd1;
    localparam logic [2:0] REG_BASE_HI = 3'd2;
    localparam logic [2:0] REG_MASK_LO = 3'd3;
    localparam logic [2:0] REG_MASK_HI = 3'd4;
    localparam logic [2:0] REG_CTRL    = 3'd5;
    localparam logic [2:0] REG_STATUS  = 3'd6;
    localparam logic [2:0] REG_HIT     = 3'd7;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_APPLY   = 1;
    localparam int CTRL_LOCK    = 7;
    localparam int STAT_OVERLAP = 0;
    localparam int STAT_MISS    = 1;

    localparam int CH_MM1      = 0;
    localparam int CH_HEX      = 1;
    localparam int CH_UART     = 2;
    localparam int CH_BOARD_IO = 3;
    localparam int CH_MM2      = 4;
    localparam int CH_IRQ      = 5;
    localparam int CH_ROM      = 6;
    localparam int CH_SDRAM    = 7;

    localparam logic [7:0] HIT_NONE = 8'hFF;

    // Listed in priority order; entries from channel 8 upward stay disabled.
    localparam logic [REG_W-1:0] DEF_BASE [MAX_CS] = '{
        16'h7FE0, 16'h7FF0, 16'h7FF4, 16'h7FF6, 16'h7FF7, 16'h7FFF, 16'h8000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    localparam logic [REG_W-1:0] DEF_MASK [MAX_CS] = '{
        16'hFFF0, 16'hFFFC, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    localparam logic DEF_EN [MAX_CS] = '{
        1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/prog_addr_decode_cs_window_match.sv
// One address window comparator: hit when enabled and the masked address equals base.
module cs_window_match #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] mask,
    input  logic              en,
    output logic              match
);

    assign match = en & ((addr & mask) == base);

endmodule

// File: rtl/prog_addr_decode.sv
// Register-programmable chip-select decoder with staged atomic window updates,
// lock, sticky overlap/miss status and last-hit capture.
module prog_addr_decode
    import prog_addr_decode_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int NUM_CS = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              addr_valid,
    output logic [NUM_CS-1:0] cs,
    output logic              miss,
    input  logic              cfg_cs,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata
);

    logic [REG_W-1:0]  act_base_q [NUM_CS];
    logic [REG_W-1:0]  act_base_d [NUM_CS];
    logic [REG_W-1:0]  act_mask_q [NUM_CS];
    logic [REG_W-1:0]  act_mask_d [NUM_CS];
    logic [NUM_CS-1:0] act_en_q, act_en_d;

    logic [REG_W-1:0]  stg_base_q, stg_base_d;
    logic [REG_W-1:0]  stg_mask_q, stg_mask_d;
    logic              stg_en_q, stg_en_d;
    logic [DATA_W-1:0] sel_q, sel_d;
    logic              lock_q, lock_d;
    logic              ovl_q, ovl_d;
    logic              miss_st_q, miss_st_d;
    logic [DATA_W-1:0] hit_q, hit_d;

    logic [NUM_CS-1:0] match;
    logic [4:0]        match_cnt;
    logic [DATA_W-1:0] win_idx;
    logic              sel_ok;
    logic              wr_en;

    for (genvar g = 0; g < NUM_CS; g++) begin : g_win
        cs_window_match #(.ADDR_W(ADDR_W)) u_match (
            .addr  (addr),
            .base  (act_base_q[g][ADDR_W-1:0]),
            .mask  (act_mask_q[g][ADDR_W-1:0]),
            .en    (act_en_q[g]),
            .match (match[g])
        );
    end

    // Fixed priority: the lowest-index matching window owns the cycle.
    always_comb begin
        cs        = '0;
        win_idx   = HIT_NONE;
        match_cnt = '0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            match_cnt = match_cnt + 5'(match[i]);
            if (match[i]) begin
                cs      = '0;
                cs[i]   = 1'b1;
                win_idx = DATA_W'(i);
            end
        end
    end

    assign miss   = ~|match;
    assign sel_ok = (sel_q < DATA_W'(NUM_CS));
    assign wr_en  = cfg_cs & cfg_we;

    always_comb begin
        act_base_d = act_base_q;
        act_mask_d = act_mask_q;
        act_en_d   = act_en_q;
        stg_base_d = stg_base_q;
        stg_mask_d = stg_mask_q;
        stg_en_d   = stg_en_q;
        sel_d      = sel_q;
        lock_d     = lock_q;
        ovl_d      = ovl_q;
        miss_st_d  = miss_st_q;
        hit_d      = hit_q;

        if (wr_en && !lock_q) begin
            case (cfg_addr)
                REG_SEL: begin
                    sel_d      = cfg_wdata;
                    stg_base_d = '0;
                    stg_mask_d = '0;
                    stg_en_d   = 1'b0;
                    for (int i = 0; i < NUM_CS; i++) begin
                        if (cfg_wdata == DATA_W'(i)) begin
                            stg_base_d = act_base_q[i];
                            stg_mask_d = act_mask_q[i];
                            stg_en_d   = act_en_q[i];
                        end
                    end
                end
                REG_BASE_LO: if (sel_ok) stg_base_d[7:0]  = cfg_wdata;
                REG_BASE_HI: if (sel_ok) stg_base_d[15:8] = cfg_wdata;
                REG_MASK_LO: if (sel_ok) stg_mask_d[7:0]  = cfg_wdata;
                REG_MASK_HI: if (sel_ok) stg_mask_d[15:8] = cfg_wdata;
                REG_CTRL: begin
                    if (sel_ok) begin
                        stg_en_d = cfg_wdata[CTRL_EN];
                        // APPLY publishes the en bit written alongside it.
                        if (cfg_wdata[CTRL_APPLY]) begin
                            for (int i = 0; i < NUM_CS; i++) begin
                                if (sel_q == DATA_W'(i)) begin
                                    act_base_d[i] = stg_base_q;
                                    act_mask_d[i] = stg_mask_q;
                                    act_en_d[i]   = stg_en_d;
                                end
                            end
                        end
                    end
                    if (cfg_wdata[CTRL_LOCK]) lock_d = 1'b1;
                end
                default: ;
            endcase
        end

        // Status clear is honoured even when locked; a same-edge set overrides it.
        if (wr_en && cfg_addr == REG_STATUS) begin
            if (cfg_wdata[STAT_OVERLAP]) ovl_d     = 1'b0;
            if (cfg_wdata[STAT_MISS])    miss_st_d = 1'b0;
        end
        if (addr_valid) begin
            if (match_cnt >= 5'd2) ovl_d     = 1'b1;
            if (miss)              miss_st_d = 1'b1;
            hit_d = win_idx;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_SEL:     cfg_rdata = sel_q;
            REG_BASE_LO: if (sel_ok) cfg_rdata = stg_base_q[7:0];
            REG_BASE_HI: if (sel_ok) cfg_rdata = stg_base_q[15:8];
            REG_MASK_LO: if (sel_ok) cfg_rdata = stg_mask_q[7:0];
            REG_MASK_HI: if (sel_ok) cfg_rdata = stg_mask_q[15:8];
            REG_CTRL:    if (sel_ok) cfg_rdata = {lock_q, 6'b0, stg_en_q};
            REG_STATUS:  cfg_rdata = {6'b0, miss_st_q, ovl_q};
            REG_HIT:     cfg_rdata = hit_q;
            default:     cfg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CS; i++) begin
                act_base_q[i] <= DEF_BASE[i];
                act_mask_q[i] <= DEF_MASK[i];
                act_en_q[i]   <= DEF_EN[i];
            end
            stg_base_q <= '0;
            stg_mask_q <= '0;
            stg_en_q   <= 1'b0;
            sel_q      <= '0;
            lock_q     <= 1'b0;
            ovl_q      <= 1'b0;
            miss_st_q  <= 1'b0;
            hit_q      <= HIT_NONE;
        end else begin
            act_base_q <= act_base_d;
            act_mask_q <= act_mask_d;
            act_en_q   <= act_en_d;
            stg_base_q <= stg_base_d;
            stg_mask_q <= stg_mask_d;
            stg_en_q   <= stg_en_d;
            sel_q      <= sel_d;
            lock_q     <= lock_d;
            ovl_q      <= ovl_d;
            miss_st_q  <= miss_st_d;
            hit_q      <= hit_d;
        end
    end

endmodule

// File: tb/tb_prog_addr_decode.sv
// Directed bench for prog_addr_decode: default-map sweep plus config-port sequences.
module tb_prog_addr_decode;

    localparam int ADDR_W = 16;
    localparam int NUM_CS = 8;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic [NUM_CS-1:0] cs;
    logic              miss;
    logic              cfg_cs;
    logic              cfg_we;
    logic [2:0]        cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic [DATA_W-1:0] cfg_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [7:0]  exp_cs;
    } range_t;

    range_t sweep [9];

    prog_addr_decode #(.ADDR_W(ADDR_W), .NUM_CS(NUM_CS), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .addr_valid (addr_valid),
        .cs         (cs),
        .miss       (miss),
        .cfg_cs     (cfg_cs),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_cs = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_cs = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic cfg_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
        @(negedge clk);
        cfg_cs = 1'b1; cfg_we = 1'b0; cfg_addr = a;
        #1;
        check(name, 32'(cfg_rdata), 32'(exp));
        cfg_cs = 1'b0;
    endtask

    task automatic cs_chk(input string name, input logic [15:0] a, input logic [7:0] exp_cs,
                          input logic exp_miss);
        @(negedge clk);
        addr = a;
        #1;
        check(name, 32'(cs), 32'(exp_cs));
        check({name, "_miss"}, 32'(miss), 32'(exp_miss));
    endtask

    task automatic strobe(input logic [15:0] a);
        @(negedge clk);
        addr = a; addr_valid = 1'b1;
        @(posedge clk);
        #1;
        addr_valid = 1'b0;
    endtask

    initial begin
        logic        ok;
        logic [7:0]  got_cs;
        logic        got_miss;
        logic [15:0] bad_addr;

        sweep[0] = '{16'h0000, 16'h7FDF, 8'h80};
        sweep[1] = '{16'h7FE0, 16'h7FEF, 8'h01};
        sweep[2] = '{16'h7FF0, 16'h7FF3, 8'h02};
        sweep[3] = '{16'h7FF4, 16'h7FF5, 8'h04};
        sweep[4] = '{16'h7FF6, 16'h7FF6, 8'h08};
        sweep[5] = '{16'h7FF7, 16'h7FF7, 8'h10};
        sweep[6] = '{16'h7FF8, 16'h7FFE, 8'h80};
        sweep[7] = '{16'h7FFF, 16'h7FFF, 8'h20};
        sweep[8] = '{16'h8000, 16'hFFFF, 8'h40};

        rst_n = 1'b0; addr = '0; addr_valid = 1'b0;
        cfg_cs = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

        // Reset state
        do_reset();
        cfg_chk("rst_sel", 3'd0, 8'h00);
        cfg_chk("rst_ctrl", 3'd5, 8'h00);
        cfg_chk("rst_base_lo", 3'd1, 8'h00);
        cfg_chk("rst_status", 3'd6, 8'h00);
        cfg_chk("rst_hit", 3'd7, 8'hFF);

        // Full sweep of the default map
        for (int r = 0; r < 9; r++) begin
            ok = 1'b1; got_cs = sweep[r].exp_cs; got_miss = 1'b0; bad_addr = '0;
            for (int a = int'(sweep[r].lo); a <= int'(sweep[r].hi); a++) begin
                addr = 16'(a);
                #1;
                if (ok && (cs !== sweep[r].exp_cs || miss !== 1'b0)) begin
                    ok = 1'b0; got_cs = cs; got_miss = miss; bad_addr = 16'(a);
                end
            end
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL sweep_%0h_%0h: at addr %h got cs=%h miss=%b, expected cs=%h miss=0",
                         sweep[r].lo, sweep[r].hi, bad_addr, got_cs, got_miss, sweep[r].exp_cs);
            end
        end

        // Atomic apply on ch1
        cfg_wr(3'd0, 8'h01);
        cfg_chk("sel1_stg_base_lo", 3'd1, 8'hF0);
        cfg_chk("sel1_stg_mask_lo", 3'd3, 8'hFC);
        cfg_wr(3'd1, 8'h40);
        cfg_wr(3'd2, 8'h60);
        cfg_wr(3'd3, 8'hF0);
        cfg_wr(3'd4, 8'hFF);
        cs_chk("pre_apply_6040", 16'h6040, 8'h80, 1'b0);
        cs_chk("pre_apply_7ff0", 16'h7FF0, 8'h02, 1'b0);
        cfg_wr(3'd5, 8'h03);
        cs_chk("post_apply_6040", 16'h6040, 8'h02, 1'b0);
        cs_chk("post_apply_7ff0", 16'h7FF0, 8'h80, 1'b0);
        cfg_chk("ctrl_apply_reads0", 3'd5, 8'h01);

        // Overlap: ch0 moved onto the ROM half
        do_reset();
        cfg_wr(3'd0, 8'h00);
        cfg_wr(3'd1, 8'h00);
        cfg_wr(3'd2, 8'h80);
        cfg_wr(3'd3, 8'h00);
        cfg_wr(3'd4, 8'hF0);
        cfg_wr(3'd5, 8'h03);
        cs_chk("ovl_cs", 16'h8010, 8'h01, 1'b0);
        strobe(16'h8010);
        cfg_chk("ovl_status", 3'd6, 8'h01);
        cfg_chk("ovl_hit", 3'd7, 8'h00);
        cfg_wr(3'd6, 8'h01);
        cfg_chk("ovl_w1c", 3'd6, 8'h00);
        @(negedge clk);
        addr = 16'h8010; addr_valid = 1'b1;
        cfg_cs = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd6; cfg_wdata = 8'h01;
        @(posedge clk);
        #1;
        addr_valid = 1'b0; cfg_cs = 1'b0; cfg_we = 1'b0;
        cfg_chk("ovl_set_wins", 3'd6, 8'h01);
        @(negedge clk);
        addr = 16'h7FF6;
        @(posedge clk);
        #1;
        cfg_chk("hit_holds", 3'd7, 8'h00);

        // Miss: ROM and SDRAM disabled
        do_reset();
        cfg_wr(3'd0, 8'h06);
        cfg_wr(3'd5, 8'h02);
        cfg_wr(3'd0, 8'h07);
        cfg_wr(3'd5, 8'h02);
        strobe(16'h7FF6);
        cfg_chk("hit_board_io", 3'd7, 8'h03);
        cfg_chk("status_clean", 3'd6, 8'h00);
        cs_chk("miss_cs", 16'h9000, 8'h00, 1'b1);
        strobe(16'h9000);
        cfg_chk("miss_status", 3'd6, 8'h02);
        cfg_chk("miss_hit", 3'd7, 8'hFF);

        // Lock
        do_reset();
        cfg_wr(3'd5, 8'h80);
        cfg_chk("lock_ctrl", 3'd5, 8'h80);
        cfg_wr(3'd0, 8'h02);
        cfg_chk("lock_sel", 3'd0, 8'h00);
        cfg_wr(3'd1, 8'h00);
        cfg_wr(3'd5, 8'h03);
        cs_chk("lock_map", 16'h7FF4, 8'h04, 1'b0);
        cfg_chk("lock_ctrl_after", 3'd5, 8'h80);
        strobe(16'h7FF0);
        cfg_chk("lock_status_set", 3'd6, 8'h01);
        cfg_wr(3'd6, 8'h01);
        cfg_chk("lock_status_w1c", 3'd6, 8'h00);
        do_reset();
        cfg_chk("unlock_ctrl", 3'd5, 8'h00);
        cfg_wr(3'd0, 8'h02);
        cfg_chk("unlock_sel", 3'd0, 8'h02);

        // Out-of-range SEL
        cfg_wr(3'd0, 8'h0F);
        for (int r = 1; r <= 5; r++) begin
            cfg_chk($sformatf("sel0f_reg%0d", r), 3'(r), 8'h00);
        end
        cfg_wr(3'd1, 8'h00);
        cfg_wr(3'd5, 8'h03);
        cs_chk("sel0f_7ff4", 16'h7FF4, 8'h04, 1'b0);
        cs_chk("sel0f_7fe0", 16'h7FE0, 8'h01, 1'b0);

        // APPLY on the reset edge is discarded
        cfg_wr(3'd0, 8'h02);
        cfg_wr(3'd1, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        cfg_cs = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd5; cfg_wdata = 8'h03;
        @(posedge clk);
        #1;
        cfg_cs = 1'b0; cfg_we = 1'b0; rst_n = 1'b1;
        cs_chk("rst_apply_7ff4", 16'h7FF4, 8'h04, 1'b0);
        cs_chk("rst_apply_7f00", 16'h7F00, 8'h80, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
